// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory and queues returned words in a 2-entry buffer for decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        p_Clk,
  input  logic        p_Rst_n,
  input  logic        p_Redirect_In,
  input  logic [31:0] p_RedirectPc_In,
  output logic        p_MemReadEn_Out,
  output logic [31:0] p_MemAddr_Out,
  input  logic [31:0] p_MemData_In,
  output logic        p_Valid_Out,
  input  logic        p_Ready_In,
  output logic [31:0] p_Instr_Out,
  output logic [31:0] p_Pc_Out,
  output logic        p_MisalignErr_Out
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_ERR
  } state_t;

  state_t      r_State;
  logic [31:0] r_Pc;
  logic [31:0] r_PendPc;
  logic        r_Pending;
  logic [1:0]  r_Count;
  logic        r_Head;
  logic        r_MisalignErr;
  logic [31:0] r_FifoInstr [2];
  logic [31:0] r_FifoPc    [2];

  logic        w_Pop;
  logic        w_Push;
  logic        w_Req;
  logic [2:0]  w_Occ;
  logic        w_WrIdx;
  logic        w_Aligned;

  // Handshake, occupancy and request decisions for the current cycle
  always_comb begin
    w_Pop     = (r_Count != 2'd0) && p_Ready_In;
    w_Push    = r_Pending && !p_Redirect_In;
    // Occupancy counts the in-flight response so the buffer can never overflow
    w_Occ     = {1'b0, r_Count} + {2'b00, r_Pending} - {2'b00, w_Pop};
    w_Req     = (r_State == S_RUN) && !p_Redirect_In && (w_Occ < 3'd2);
    // Tail slot is head + count (mod 2); with count 2 this is the slot being freed by the pop
    w_WrIdx   = r_Head ^ r_Count[0];
    w_Aligned = (p_RedirectPc_In[1:0] == 2'b00);
  end

  assign p_MemReadEn_Out   = w_Req;
  assign p_MemAddr_Out     = r_Pc;
  assign p_Valid_Out       = (r_Count != 2'd0);
  assign p_Instr_Out       = p_Valid_Out ? r_FifoInstr[r_Head] : NOP_INSTR;
  assign p_Pc_Out          = p_Valid_Out ? r_FifoPc[r_Head] : '0;
  assign p_MisalignErr_Out = r_MisalignErr;

  // Control FSM: PC, pending response, buffer pointers and sticky error
  always_ff @(posedge p_Clk or negedge p_Rst_n) begin
    if (!p_Rst_n) begin
      r_State       <= S_BOOT;
      r_Pc          <= RESET_PC;
      r_PendPc      <= '0;
      r_Pending     <= 1'b0;
      r_Count       <= '0;
      r_Head        <= 1'b0;
      r_MisalignErr <= 1'b0;
    end else if (p_Redirect_In) begin
      r_Count   <= '0;
      r_Head    <= 1'b0;
      r_Pending <= 1'b0;
      if (!w_Aligned) begin
        r_State       <= S_ERR;
        r_MisalignErr <= 1'b1;
      end else begin
        r_Pc <= p_RedirectPc_In;
        if (r_State == S_BOOT) begin
          r_State <= S_RUN;
        end
      end
    end else begin
      if (r_State == S_BOOT) begin
        r_State <= S_RUN;
      end
      if (w_Req) begin
        r_Pc      <= r_Pc + 32'd4;
        r_PendPc  <= r_Pc;
        r_Pending <= 1'b1;
      end else begin
        r_Pending <= 1'b0;
      end
      r_Count <= r_Count + {1'b0, w_Push} - {1'b0, w_Pop};
      if (w_Pop) begin
        r_Head <= ~r_Head;
      end
    end
  end

  // Buffer storage: capture the returned word and its PC at the tail slot
  always_ff @(posedge p_Clk or negedge p_Rst_n) begin
    if (!p_Rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_FifoInstr[i] <= '0;
        r_FifoPc[i]    <= '0;
      end
    end else if (w_Push) begin
      r_FifoInstr[w_WrIdx] <= p_MemData_In;
      r_FifoPc[w_WrIdx]    <= r_PendPc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle synchronous memory model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        redir;
  logic [31:0] redir_pc;
  logic        rden;
  logic [31:0] addr;
  logic [31:0] mem_data;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        err;

  int checks;
  int errors;

  instr_fetch #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .p_Clk            (clk),
    .p_Rst_n          (rst_n),
    .p_Redirect_In    (redir),
    .p_RedirectPc_In  (redir_pc),
    .p_MemReadEn_Out  (rden),
    .p_MemAddr_Out    (addr),
    .p_MemData_In     (mem_data),
    .p_Valid_Out      (valid),
    .p_Ready_In       (ready),
    .p_Instr_Out      (instr),
    .p_Pc_Out         (pc),
    .p_MisalignErr_Out(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  // Instruction memory: data the cycle after a sampled request, 0 otherwise
  always @(posedge clk) begin
    mem_data <= rden ? mem_word(addr) : 32'h0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert (dut.r_Count != 2'd3) else $error("buffer count exceeded 2");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic e_rden, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc, input logic e_err);
    chk({tag, "_rden"}, {31'b0, rden}, {31'b0, e_rden});
    chk({tag, "_addr"}, addr, e_addr);
    chk({tag, "_valid"}, {31'b0, valid}, {31'b0, e_valid});
    chk({tag, "_pc"}, pc, e_valid ? e_pc : 32'h0);
    chk({tag, "_instr"}, instr, e_valid ? mem_word(e_pc) : NOP_INSTR);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, e_err});
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        rden;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        err;
  } vec_t;

  vec_t vecs [23];

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    redir    = 1'b0;
    redir_pc = 32'h0;
    ready    = 1'b0;
    mem_data = 32'h0;

    // Cycle 0 is the boot cycle after release; inputs applied, outputs checked before the edge.
    //          redir  rpc            ready  rden  addr           valid  pc             err
    vecs[0]  = '{1'b0, 32'h0,         1'b0,  1'b0, 32'h0,         1'b0,  32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0,  1'b1, 32'h0,         1'b0,  32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h0,         1'b0,  1'b1, 32'h4,         1'b0,  32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0,         1'b0,  1'b0, 32'h8,         1'b1,  32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0,         1'b0,  1'b0, 32'h8,         1'b1,  32'h0,         1'b0};
    vecs[5]  = '{1'b0, 32'h0,         1'b0,  1'b0, 32'h8,         1'b1,  32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h0,         1'b0,  1'b0, 32'h8,         1'b1,  32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0,         1'b0,  1'b0, 32'h8,         1'b1,  32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'h0,         1'b1,  1'b1, 32'h8,         1'b1,  32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h0,         1'b1,  1'b1, 32'hC,         1'b1,  32'h4,         1'b0};
    vecs[10] = '{1'b1, 32'h100,       1'b1,  1'b0, 32'h10,        1'b1,  32'h8,         1'b0};
    vecs[11] = '{1'b0, 32'h0,         1'b1,  1'b1, 32'h100,       1'b0,  32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h0,         1'b1,  1'b1, 32'h104,       1'b0,  32'h0,         1'b0};
    vecs[13] = '{1'b0, 32'h0,         1'b1,  1'b1, 32'h108,       1'b1,  32'h100,       1'b0};
    vecs[14] = '{1'b1, 32'hFFFF_FFFC, 1'b1,  1'b0, 32'h10C,       1'b1,  32'h104,       1'b0};
    vecs[15] = '{1'b0, 32'h0,         1'b1,  1'b1, 32'hFFFF_FFFC, 1'b0,  32'h0,         1'b0};
    vecs[16] = '{1'b0, 32'h0,         1'b1,  1'b1, 32'h0,         1'b0,  32'h0,         1'b0};
    vecs[17] = '{1'b0, 32'h0,         1'b1,  1'b1, 32'h4,         1'b1,  32'hFFFF_FFFC, 1'b0};
    vecs[18] = '{1'b0, 32'h0,         1'b1,  1'b1, 32'h8,         1'b1,  32'h0,         1'b0};
    vecs[19] = '{1'b1, 32'h102,       1'b1,  1'b0, 32'hC,         1'b1,  32'h4,         1'b0};
    vecs[20] = '{1'b0, 32'h0,         1'b1,  1'b0, 32'hC,         1'b0,  32'h0,         1'b1};
    vecs[21] = '{1'b0, 32'h0,         1'b1,  1'b0, 32'hC,         1'b0,  32'h0,         1'b1};
    vecs[22] = '{1'b0, 32'h0,         1'b1,  1'b0, 32'hC,         1'b0,  32'h0,         1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    #1 expect_all("rst", 1'b0, RESET_PC, 1'b0, 32'h0, 1'b0);

    // Stream, stall, redirect, wrap and misaligned redirect
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      redir    = vecs[i].redir;
      redir_pc = vecs[i].rpc;
      ready    = vecs[i].ready;
      #1 expect_all($sformatf("v%0d", i), vecs[i].rden, vecs[i].addr, vecs[i].valid,
                    vecs[i].pc, vecs[i].err);
      @(negedge clk);
    end

    // Reset clears the sticky error and restarts at RESET_PC
    redir = 1'b0;
    ready = 1'b0;
    rst_n = 1'b0;
    #1 expect_all("err_rst", 1'b0, RESET_PC, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 expect_all("r1_c0", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1 expect_all("r1_c1", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1 expect_all("r1_c2", 1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1 expect_all("r1_c3", 1'b0, 32'h8, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    #1 expect_all("r1_c4", 1'b0, 32'h8, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    ready = 1'b1;
    #1 expect_all("r1_c5", 1'b1, 32'h8, 1'b1, 32'h0, 1'b0);

    // Asynchronous reset mid-cycle with two entries buffered
    #2 rst_n = 1'b0;
    #1 expect_all("async_rst", 1'b0, RESET_PC, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 expect_all("r2_c0", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1 expect_all("r2_c1", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1 expect_all("r2_c2", 1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1 expect_all("r2_c3", 1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    #1 expect_all("r2_c4", 1'b1, 32'hC, 1'b1, 32'h4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
